// File: rtl/intr_pkg.sv
// -----------------------------------------------------------------------------
// intr_pkg
// Shared constants and types for the interrupt controller:
//   - default source count and priority width
//   - claim ID width (IDs 1..31, 0 means "no interrupt")
//   - register word addresses
//   - prio_t, a priority value at the default width
// -----------------------------------------------------------------------------
package intr_pkg;

    localparam int NSRC_DEFAULT   = 4;
    localparam int PRIO_W_DEFAULT = 3;
    localparam int ID_W           = 5;

    localparam logic [7:0] ADDR_ENABLE      = 8'h00;
    localparam logic [7:0] ADDR_THRESHOLD   = 8'h01;
    localparam logic [7:0] ADDR_CLAIM       = 8'h02;
    localparam logic [7:0] ADDR_PENDING     = 8'h03;
    localparam logic [7:0] ADDR_MTIME_LO    = 8'h04;
    localparam logic [7:0] ADDR_MTIME_HI    = 8'h05;
    localparam logic [7:0] ADDR_MTIMECMP_LO = 8'h06;
    localparam logic [7:0] ADDR_MTIMECMP_HI = 8'h07;
    localparam logic [7:0] ADDR_PRIO_BASE   = 8'h10;

    typedef logic [PRIO_W_DEFAULT-1:0] prio_t;

endpackage

// File: rtl/intr_arbiter.sv
// -----------------------------------------------------------------------------
// intr_arbiter
// Purely combinational winner selection.
//   pending, enable : per-source request state and mask
//   prio_flat       : source priorities, source i at [i*PRIO_W +: PRIO_W]
//   threshold       : a source must have priority strictly above this
//   win_id          : ID (source index + 1) of the winner, 0 when none
//   win_valid       : a winner exists
// -----------------------------------------------------------------------------
module intr_arbiter
    import intr_pkg::*;
#(
    parameter int NSRC   = NSRC_DEFAULT,
    parameter int PRIO_W = PRIO_W_DEFAULT
) (
    input  logic [NSRC-1:0]        pending,
    input  logic [NSRC-1:0]        enable,
    input  logic [NSRC*PRIO_W-1:0] prio_flat,
    input  logic [PRIO_W-1:0]      threshold,
    output logic [ID_W-1:0]        win_id,
    output logic                   win_valid
);

    logic [PRIO_W-1:0] best_prio_s;

    // Scan from the lowest ID upward; a strict '>' keeps the lowest ID on ties
    // and, because best starts at threshold (>= 0), priority 0 can never win.
    always_comb begin
        best_prio_s = threshold;
        win_id      = {ID_W{1'b0}};
        win_valid   = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (pending[i] && enable[i] &&
                (prio_flat[i*PRIO_W +: PRIO_W] > best_prio_s)) begin
                best_prio_s = prio_flat[i*PRIO_W +: PRIO_W];
                win_id      = ID_W'(i + 1);
                win_valid   = 1'b1;
            end else begin
                best_prio_s = best_prio_s;
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// -----------------------------------------------------------------------------
// intr_ctrl
// Small platform interrupt controller with a machine timer.
//   clk, rst    : clock, asynchronous active-high reset
//   src         : level interrupt requests, bit i is ID i+1
//   wr_en/rd_en : register write / read strobes, addr is the word address
//   wr_data     : write data
//   rd_data     : read data, registered, valid the cycle after rd_en
//   ext_intr    : registered "a winner exists"
//   timer_intr  : registered mtime >= mtimecmp
// Reading the claim register claims the winner; writing an ID to it completes.
// -----------------------------------------------------------------------------
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int NSRC     = NSRC_DEFAULT,
    parameter int PRIO_W   = PRIO_W_DEFAULT,
    parameter int TICK_DIV = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src,
    input  logic            wr_en,
    input  logic            rd_en,
    input  logic [7:0]      addr,
    input  logic [31:0]     wr_data,
    output logic [31:0]     rd_data,
    output logic            ext_intr,
    output logic            timer_intr
);

    logic [NSRC-1:0]        enable_r;
    logic [PRIO_W-1:0]      threshold_r;
    logic [NSRC*PRIO_W-1:0] prio_r;
    logic [NSRC-1:0]        pending_r;
    logic [NSRC-1:0]        inservice_r;
    logic [NSRC-1:0]        pending_nxt_s;
    logic [NSRC-1:0]        inservice_nxt_s;
    logic [63:0]            mtime_r;
    logic [63:0]            mtime_nxt_s;
    logic [63:0]            mtimecmp_r;
    logic [31:0]            presc_r;
    logic [31:0]            presc_nxt_s;
    logic [31:0]            rd_data_r;
    logic [31:0]            rd_mux_s;
    logic                   ext_intr_r;
    logic                   timer_intr_r;
    logic [ID_W-1:0]        win_id_s;
    logic                   win_valid_s;
    logic                   claim_s;
    logic                   cmpl_wr_s;
    logic                   tick_s;
    logic [7:0]             prio_off_s;
    logic                   prio_hit_s;

    assign claim_s    = rd_en && (addr == ADDR_CLAIM);
    assign cmpl_wr_s  = wr_en && (addr == ADDR_CLAIM);
    assign prio_off_s = addr - ADDR_PRIO_BASE;
    assign prio_hit_s = (addr >= ADDR_PRIO_BASE) && (prio_off_s < 8'(NSRC));
    assign tick_s     = (presc_r == 32'(TICK_DIV - 1));

    assign rd_data    = rd_data_r;
    assign ext_intr   = ext_intr_r;
    assign timer_intr = timer_intr_r;

    intr_arbiter #(
        .NSRC   (NSRC),
        .PRIO_W (PRIO_W)
    ) u_arbiter (
        .pending   (pending_r),
        .enable    (enable_r),
        .prio_flat (prio_r),
        .threshold (threshold_r),
        .win_id    (win_id_s),
        .win_valid (win_valid_s)
    );

    // Gateway and claim/complete bookkeeping. pending and inservice are never
    // both set for one source, so a claim and a complete cannot hit the same bit.
    always_comb begin
        pending_nxt_s   = pending_r;
        inservice_nxt_s = inservice_r;
        for (int i = 0; i < NSRC; i++) begin
            if (cmpl_wr_s && (wr_data == 32'(i + 1))) begin
                inservice_nxt_s[i] = 1'b0;
            end else begin
                inservice_nxt_s[i] = inservice_r[i];
            end
            if (claim_s && win_valid_s && (win_id_s == ID_W'(i + 1))) begin
                pending_nxt_s[i]   = 1'b0;
                inservice_nxt_s[i] = 1'b1;
            end else if (src[i] && !pending_r[i] && !inservice_r[i]) begin
                pending_nxt_s[i] = 1'b1;
            end else begin
                pending_nxt_s[i] = pending_r[i];
            end
        end
    end

    // Prescaler and mtime next state; any mtime write suppresses that cycle's tick.
    always_comb begin
        presc_nxt_s = presc_r;
        mtime_nxt_s = mtime_r;
        if (tick_s) begin
            presc_nxt_s = 32'd0;
        end else begin
            presc_nxt_s = presc_r + 32'd1;
        end
        if (wr_en && (addr == ADDR_MTIME_LO)) begin
            mtime_nxt_s[31:0] = wr_data;
        end else if (wr_en && (addr == ADDR_MTIME_HI)) begin
            mtime_nxt_s[63:32] = wr_data;
        end else if (tick_s) begin
            mtime_nxt_s = mtime_r + 64'd1;
        end else begin
            mtime_nxt_s = mtime_r;
        end
    end

    // Read data selection; unmapped addresses and unused upper bits give 0.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        if (prio_hit_s) begin
            for (int i = 0; i < NSRC; i++) begin
                if (prio_off_s == 8'(i)) begin
                    rd_mux_s[PRIO_W-1:0] = prio_r[i*PRIO_W +: PRIO_W];
                end else begin
                    rd_mux_s = rd_mux_s;
                end
            end
        end else begin
            case (addr)
                ADDR_ENABLE:      rd_mux_s[NSRC-1:0]   = enable_r;
                ADDR_THRESHOLD:   rd_mux_s[PRIO_W-1:0] = threshold_r;
                ADDR_CLAIM:       rd_mux_s[ID_W-1:0]   = win_id_s;
                ADDR_PENDING:     rd_mux_s[NSRC-1:0]   = pending_r;
                ADDR_MTIME_LO:    rd_mux_s             = mtime_r[31:0];
                ADDR_MTIME_HI:    rd_mux_s             = mtime_r[63:32];
                ADDR_MTIMECMP_LO: rd_mux_s             = mtimecmp_r[31:0];
                ADDR_MTIMECMP_HI: rd_mux_s             = mtimecmp_r[63:32];
                default:          rd_mux_s             = 32'h0000_0000;
            endcase
        end
    end

    // Software-written configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_r    <= {NSRC{1'b0}};
            threshold_r <= {PRIO_W{1'b0}};
            prio_r      <= {(NSRC*PRIO_W){1'b0}};
            mtimecmp_r  <= {64{1'b1}};
        end else if (wr_en) begin
            case (addr)
                ADDR_ENABLE:      enable_r           <= wr_data[NSRC-1:0];
                ADDR_THRESHOLD:   threshold_r        <= wr_data[PRIO_W-1:0];
                ADDR_MTIMECMP_LO: mtimecmp_r[31:0]   <= wr_data;
                ADDR_MTIMECMP_HI: mtimecmp_r[63:32]  <= wr_data;
                default:          enable_r           <= enable_r;
            endcase
            for (int i = 0; i < NSRC; i++) begin
                if (prio_hit_s && (prio_off_s == 8'(i))) begin
                    prio_r[i*PRIO_W +: PRIO_W] <= wr_data[PRIO_W-1:0];
                end
            end
        end
    end

    // Interrupt source state; reset drops any claim in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r   <= {NSRC{1'b0}};
            inservice_r <= {NSRC{1'b0}};
        end else begin
            pending_r   <= pending_nxt_s;
            inservice_r <= inservice_nxt_s;
        end
    end

    // Machine timer and its prescaler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_r <= 64'd0;
            presc_r <= 32'd0;
        end else begin
            mtime_r <= mtime_nxt_s;
            presc_r <= presc_nxt_s;
        end
    end

    // Registered outputs; rd_data holds while no read is strobed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r    <= 32'h0000_0000;
            ext_intr_r   <= 1'b0;
            timer_intr_r <= 1'b0;
        end else begin
            ext_intr_r   <= win_valid_s;
            timer_intr_r <= (mtime_r >= mtimecmp_r);
            if (rd_en) begin
                rd_data_r <= rd_mux_s;
            end
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_intr_ctrl
// Directed bench for intr_ctrl (NSRC=4, PRIO_W=3, TICK_DIV=1): a register
// table followed by hand-written claim/complete and timer sequences.
// -----------------------------------------------------------------------------
module tb_intr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        ext_intr;
    logic        timer_intr;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic        wr;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[24];

    intr_ctrl #(
        .NSRC     (4),
        .PRIO_W   (3),
        .TICK_DIV (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src        (src),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .addr       (addr),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .ext_intr   (ext_intr),
        .timer_intr (timer_intr)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
        addr    = a;
        wr_data = d;
        wr_en   = 1'b1;
        step(1);
        wr_en   = 1'b0;
    endtask

    task automatic reg_rd(input logic [7:0] a, output logic [31:0] d);
        addr  = a;
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        d     = rd_data;
    endtask

    task automatic do_reset;
        rst     = 1'b1;
        src     = 4'h0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        addr    = 8'h00;
        wr_data = 32'h0;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] d;

        vecs[0]  = '{1'b0, 8'h00, 32'h0,         32'h0000_0000};
        vecs[1]  = '{1'b0, 8'h01, 32'h0,         32'h0000_0000};
        vecs[2]  = '{1'b0, 8'h03, 32'h0,         32'h0000_0000};
        vecs[3]  = '{1'b0, 8'h06, 32'h0,         32'hFFFF_FFFF};
        vecs[4]  = '{1'b0, 8'h07, 32'h0,         32'hFFFF_FFFF};
        vecs[5]  = '{1'b0, 8'h13, 32'h0,         32'h0000_0000};
        vecs[6]  = '{1'b0, 8'h02, 32'h0,         32'h0000_0000};
        vecs[7]  = '{1'b0, 8'h05, 32'h0,         32'h0000_0000};
        vecs[8]  = '{1'b1, 8'h00, 32'hFFFF_FFFF, 32'h0};
        vecs[9]  = '{1'b0, 8'h00, 32'h0,         32'h0000_000F};
        vecs[10] = '{1'b1, 8'h01, 32'hFFFF_FFFF, 32'h0};
        vecs[11] = '{1'b0, 8'h01, 32'h0,         32'h0000_0007};
        vecs[12] = '{1'b1, 8'h13, 32'hFFFF_FFFF, 32'h0};
        vecs[13] = '{1'b0, 8'h13, 32'h0,         32'h0000_0007};
        vecs[14] = '{1'b1, 8'h14, 32'h0000_0003, 32'h0};
        vecs[15] = '{1'b0, 8'h14, 32'h0,         32'h0000_0000};
        vecs[16] = '{1'b1, 8'h03, 32'h0000_000F, 32'h0};
        vecs[17] = '{1'b0, 8'h03, 32'h0,         32'h0000_0000};
        vecs[18] = '{1'b0, 8'h3F, 32'h0,         32'h0000_0000};
        vecs[19] = '{1'b1, 8'h06, 32'h0000_1234, 32'h0};
        vecs[20] = '{1'b0, 8'h06, 32'h0,         32'h0000_1234};
        vecs[21] = '{1'b0, 8'h07, 32'h0,         32'hFFFF_FFFF};
        vecs[22] = '{1'b1, 8'h10, 32'h0000_0002, 32'h0};
        vecs[23] = '{1'b0, 8'h10, 32'h0,         32'h0000_0002};

        // Reset values and register table
        do_reset();
        check("reset_rd_data", rd_data, 32'h0);
        check("reset_ext_intr", {31'd0, ext_intr}, 32'h0);
        check("reset_timer_intr", {31'd0, timer_intr}, 32'h0);
        for (int i = 0; i < 24; i++) begin
            if (vecs[i].wr) begin
                reg_wr(vecs[i].a, vecs[i].d);
            end else begin
                reg_rd(vecs[i].a, d);
                check($sformatf("table[%0d]_addr_%02h", i, vecs[i].a), d, vecs[i].exp);
            end
        end

        // Equal priorities, lowest ID wins first
        do_reset();
        reg_wr(8'h11, 32'd5);
        reg_wr(8'h12, 32'd5);
        reg_wr(8'h00, 32'h6);
        reg_wr(8'h01, 32'd0);
        src = 4'b0110;
        step(1);
        check("tie_ext_same_edge", {31'd0, ext_intr}, 32'h0);
        src = 4'b0000;
        step(1);
        check("tie_ext_next_cycle", {31'd0, ext_intr}, 32'h1);
        reg_rd(8'h03, d);
        check("tie_pending", d, 32'h6);
        reg_rd(8'h02, d);
        check("tie_claim_first", d, 32'd2);
        reg_rd(8'h02, d);
        check("tie_claim_second", d, 32'd3);
        step(1);
        check("tie_ext_drops", {31'd0, ext_intr}, 32'h0);

        // Threshold is a strict bound
        do_reset();
        reg_wr(8'h10, 32'd5);
        reg_wr(8'h00, 32'h1);
        reg_wr(8'h01, 32'd5);
        src = 4'b0001;
        step(3);
        check("thr_equal_blocks", {31'd0, ext_intr}, 32'h0);
        reg_wr(8'h01, 32'd4);
        check("thr_lowered_same_edge", {31'd0, ext_intr}, 32'h0);
        step(1);
        check("thr_lowered_next_cycle", {31'd0, ext_intr}, 32'h1);

        // Claim/complete with the source held high
        reg_rd(8'h02, d);
        check("held_claim", d, 32'd1);
        reg_rd(8'h03, d);
        check("held_pending_cleared", d, 32'h0);
        reg_wr(8'h02, 32'd1);
        reg_rd(8'h03, d);
        check("held_pending_at_complete_edge", d, 32'h0);
        reg_rd(8'h03, d);
        check("held_pending_repends", d, 32'h1);
        reg_rd(8'h02, d);
        check("held_claim_again", d, 32'd1);
        reg_wr(8'h02, 32'd7);
        reg_wr(8'h02, 32'd5);
        reg_wr(8'h02, 32'd0);
        reg_wr(8'h02, 32'd2);
        step(2);
        reg_rd(8'h03, d);
        check("bad_complete_ignored", d, 32'h0);
        check("bad_complete_ext", {31'd0, ext_intr}, 32'h0);

        // Timer compare at mtimecmp = 100
        do_reset();
        reg_wr(8'h06, 32'd100);
        reg_wr(8'h07, 32'd0);
        check("timer_low_before", {31'd0, timer_intr}, 32'h0);
        reg_wr(8'h04, 32'd90);
        reg_rd(8'h04, d);
        check("mtime_written", d, 32'd90);
        step(9);
        check("timer_at_99", {31'd0, timer_intr}, 32'h0);
        step(1);
        check("timer_at_100", {31'd0, timer_intr}, 32'h1);
        reg_wr(8'h07, 32'hFFFF_FFFF);
        check("timer_cmp_hi_edge", {31'd0, timer_intr}, 32'h1);
        reg_wr(8'h06, 32'hFFFF_FFFF);
        check("timer_falls", {31'd0, timer_intr}, 32'h0);

        // mtime wrap with mtimecmp all-ones
        reg_wr(8'h05, 32'hFFFF_FFFF);
        reg_wr(8'h04, 32'hFFFF_FFFF);
        check("wrap_timer_before", {31'd0, timer_intr}, 32'h0);
        reg_rd(8'h04, d);
        check("wrap_lo_all_ones", d, 32'hFFFF_FFFF);
        check("wrap_timer_at_max", {31'd0, timer_intr}, 32'h1);
        reg_rd(8'h05, d);
        check("wrap_hi_zero", d, 32'h0);
        check("wrap_timer_after", {31'd0, timer_intr}, 32'h0);
        reg_rd(8'h04, d);
        check("wrap_lo_counts", d, 32'd1);

        // Reset in the middle of a claim
        reg_wr(8'h10, 32'd3);
        reg_wr(8'h00, 32'h1);
        reg_wr(8'h06, 32'd0);
        reg_wr(8'h07, 32'd0);
        src = 4'b0001;
        step(2);
        reg_rd(8'h10, d);
        check("pre_rst_ext", {31'd0, ext_intr}, 32'h1);
        check("pre_rst_timer", {31'd0, timer_intr}, 32'h1);
        addr  = 8'h02;
        rd_en = 1'b1;
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        check("mid_rst_rd_data", rd_data, 32'h0);
        check("mid_rst_ext", {31'd0, ext_intr}, 32'h0);
        check("mid_rst_timer", {31'd0, timer_intr}, 32'h0);
        rst = 1'b0;
        step(1);
        reg_rd(8'h03, d);
        check("mid_rst_no_stale_inservice", d, 32'h1);
        reg_rd(8'h06, d);
        check("mid_rst_mtimecmp_lo", d, 32'hFFFF_FFFF);
        reg_rd(8'h07, d);
        check("mid_rst_mtimecmp_hi", d, 32'hFFFF_FFFF);
        reg_rd(8'h00, d);
        check("mid_rst_enable", d, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have parameter NSRC, default 4, number of external interrupt sources, legal 1..31.
REQ-002 SHALL have parameter PRIO_W, default 3, width of each source priority and of the threshold.
REQ-003 SHALL have parameter TICK_DIV, default 1, clock cycles per mtime increment, legal >=1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 src  input  NSRC  level-sensitive interrupt requests; bit i maps to ID i+1.
REQ-007 wr_en  input  1  register write strobe.
REQ-008 rd_en  input  1  register read strobe.
REQ-009 addr  input  8  word address for the read or write.
REQ-010 wr_data  input  32  write data.
REQ-011 rd_data  output  32  read data, valid the cycle after rd_en.
REQ-012 ext_intr  output  1  external interrupt request to the core.
REQ-013 timer_intr  output  1  timer interrupt request to the core.

Function
REQ-014 Register map SHALL be: 0x00 enable[NSRC-1:0]; 0x01 threshold; 0x02 claim/complete; 0x03 pending (read-only); 0x04/0x05 mtime lo/hi; 0x06/0x07 mtimecmp lo/hi; 0x10+i priority of source i.
REQ-015 Unmapped reads SHALL return 0; unmapped writes and writes to 0x03 SHALL be ignored; unused upper bits SHALL read 0.
REQ-016 Gateway: pending[i] SHALL set when src[i]=1, pending[i]=0 and inservice[i]=0.
REQ-017 Winner SHALL be the pending, enabled source with the highest priority that is strictly greater than threshold; ties go to the lowest ID; priority 0 never wins.
REQ-018 ext_intr SHALL be registered and assert one cycle after a winner exists; it SHALL deassert one cycle after no winner exists.
REQ-019 Read of 0x02 with rd_en SHALL return the winner ID (0 if none), clear that pending bit and set its inservice bit in the same edge.
REQ-020 Write of ID to 0x02 SHALL clear inservice[ID-1]; ID 0, ID>NSRC or a non-in-service ID SHALL be ignored.
REQ-021 After complete, a source whose src is still high SHALL re-pend on the next edge.
REQ-022 Claim in the same cycle as src rising SHALL follow REQ-019: the claimed bit clears and stays clear while inservice=1.
REQ-023 mtime (64 bit) SHALL increment once every TICK_DIV cycles, wrapping from all-ones to 0.
REQ-024 A write to mtime lo/hi SHALL take precedence over an increment in the same cycle.
REQ-025 timer_intr SHALL be a registered (mtime >= mtimecmp), unsigned 64-bit compare, updated every cycle.
REQ-026 rd_data SHALL hold its last value when rd_en=0.

Reset
REQ-027 While rst is high, the block SHALL clear enable, threshold, pending, inservice, all priorities, mtime, the prescaler, rd_data, ext_intr and timer_intr to 0, and set mtimecmp to all-ones.
REQ-028 Reset asserted mid-claim SHALL discard the claim; after release no stale ID SHALL be in service.

Structure
REQ-029 Package intr_pkg SHALL hold the address constants, the prio_t typedef (PRIO_W bits) and the NSRC default.
REQ-030 Sub-module intr_arbiter (combinational; pending, enable, priorities, threshold -> winner ID and valid) SHALL implement REQ-017.
REQ-031 Target size SHALL be 120-400 lines of RTL in total.

Verification
REQ-032 Setup prio[1]=5, prio[2]=5, enable=0x6, threshold=0, pulse src[1] and src[2] together -> ext_intr=1 one cycle later; claim returns 2, then 3.
REQ-033 threshold=5, prio[0]=5, src[0] high -> ext_intr stays 0; threshold=4 -> ext_intr=1 one cycle later.
REQ-034 src[0] held high, claim returns 1, complete with 1 -> pending[0] re-sets next cycle; complete with 7 (NSRC=4) -> no state change.
REQ-035 TICK_DIV=1, mtimecmp=100 -> timer_intr rises exactly at mtime=100; writing mtimecmp=0xFFFF_FFFF_FFFF_FFFF -> timer_intr falls next cycle.
REQ-036 mtime=0xFFFF_FFFF_FFFF_FFFF -> wraps to 0 next tick; mid-operation rst pulse -> all outputs 0, mtimecmp reads all-ones.
